// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction loader (LOADER_CHECKSUM_EN adds S_CSUM)
package loader_pkg;

  localparam int INSTR_W   = 9;
  localparam int LEN_BYTES = 2;

  // Bits of the hi byte that carry word bits [w-1:8]; everything above must be zero.
  function automatic logic [7:0] hi_mask(int w);
    return 8'((1 << (w - 8)) - 1);
  endfunction

  localparam logic [7:0] HI_VALID_MASK = hi_mask(INSTR_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_W_HI,
    S_W_LO,
    S_DONE,
    S_ERR
`ifdef LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } loader_state_t;

endpackage

// File: rtl/loader_csum.sv
// rtl/loader_csum.sv - running XOR of accepted frame bytes
module loader_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= 8'h00;
    end else if (clr) begin
      acc <= 8'h00;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - byte-stream program loader writing the instruction memory
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_loader
  import loader_pkg::*;
#(
  parameter int D = 12,
  parameter int W = INSTR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic [D-1:0] word_count,
  output logic         load_done,
  output logic         cpu_hold,
  output logic         err
);

  localparam logic [7:0]   HI_MASK = (W == INSTR_W) ? HI_VALID_MASK : hi_mask(W);
  localparam logic [16:0]  MAX_N   = 17'd1 << D;
  localparam logic [D-1:0] WC_MAX  = '1;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = S_CSUM;
`else
  localparam loader_state_t END_ST = S_DONE;
`endif

  loader_state_t state, state_nx;

  logic [8*LEN_BYTES-9:0] len_hi_q;
  logic [15:0]            rem_q;
  logic [7:0]             hi_q;
  logic [15:0]            n_len;
  logic                   fire;
  logic                   start_ok;
  logic                   csum_match;

  assign fire     = in_valid && in_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign n_len    = {len_hi_q, in_data};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;

  loader_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clr   (start_ok),
    .en    (fire && state != S_CSUM),
    .din   (in_data),
    .acc   (csum_acc)
  );

  assign csum_match = (csum_acc == in_data);
`else
  assign csum_match = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        if (fire) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        if (fire) begin
          if ({1'b0, n_len} > MAX_N) state_nx = S_ERR;
          else if (n_len == 16'd0)   state_nx = END_ST;
          else                       state_nx = S_W_HI;
        end
      end
      S_W_HI: begin
        in_ready = 1'b1;
        if (fire) state_nx = ((in_data & ~HI_MASK) != 8'h00) ? S_ERR : S_W_LO;
      end
      S_W_LO: begin
        in_ready = 1'b1;
        if (fire) state_nx = (rem_q == 16'd1) ? END_ST : S_W_HI;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (fire) state_nx = csum_match ? S_DONE : S_ERR;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

  assign load_done = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign cpu_hold  = ~load_done;

  // Write port is registered so address/data are stable for the whole wr_en cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_q   <= '0;
      rem_q      <= 16'd0;
      hi_q       <= 8'h00;
      word_count <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_en      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (start_ok) begin
        word_count <= '0;
        wr_addr    <= '0;
      end
      if (fire) begin
        case (state)
          S_LEN_HI: len_hi_q <= in_data;
          S_LEN_LO: rem_q    <= n_len;
          S_W_HI:   hi_q     <= in_data;
          S_W_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= word_count;
            wr_data <= W'({hi_q, in_data});
            rem_q   <= rem_q - 16'd1;
            // A full 2**D load leaves the count parked at the last address.
            if (word_count != WC_MAX) word_count <= word_count + D'(1);
          end
          default: ;
        endcase
      end
    end
  end

  logic unused_ok;
  assign unused_ok = csum_match;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - scoreboard bench for instr_loader
module tb_instr_loader;

  localparam int D = 12;
  localparam int W = 9;

  logic         clk;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [W-1:0] wr_data;
  logic [D-1:0] word_count;
  logic         load_done;
  logic         cpu_hold;
  logic         err;

  instr_loader #(.D(D), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .word_count (word_count),
    .load_done  (load_done),
    .cpu_hold   (cpu_hold),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [D-1:0] a;
    logic [W-1:0] d;
  } wr_t;

  wr_t         sb[$];
  wr_t         exp_wr;
  logic [15:0] frame_q[$];
  logic [7:0]  xsum;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("extra_wr_en", 1, 0);
      end else begin
        exp_wr = sb.pop_front();
        check("wr_addr", wr_addr, exp_wr.a);
        check("wr_data", wr_data, exp_wr.d);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output bit acc);
    acc = 1'b0;
    if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_ok(input logic [7:0] b, input int gap);
    bit acc;
    send_byte(b, gap, acc);
    xsum ^= b;
    check("byte_accepted", acc, 1);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xsum = 8'h00;
  endtask

  task automatic send_frame(input int gap, input bit mid_start);
    logic [15:0] n;
    logic [15:0] w;
    n = 16'(frame_q.size());
    send_ok(n[15:8], gap);
    send_ok(n[7:0], gap);
    if (mid_start) begin
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < frame_q.size(); k++) begin
      w = frame_q[k];
      send_ok(w[15:8], gap);
      sb.push_back('{a: D'(k), d: W'(w)});
      send_ok(w[7:0], gap);
    end
`ifdef LOADER_CHECKSUM_EN
    send_ok(xsum, gap);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready,   0);
    check({tag, "_wr_en"},      wr_en,      0);
    check({tag, "_wr_addr"},    wr_addr,    0);
    check({tag, "_wr_data"},    wr_data,    0);
    check({tag, "_word_count"}, word_count, 0);
    check({tag, "_load_done"},  load_done,  0);
    check({tag, "_err"},        err,        0);
    check({tag, "_cpu_hold"},   cpu_hold,   1);
  endtask

  task automatic check_done(input string tag, input int words);
    repeat (3) @(negedge clk);
    check({tag, "_sb_empty"},   sb.size(),  0);
    check({tag, "_word_count"}, word_count, words);
    check({tag, "_load_done"},  load_done,  1);
    check({tag, "_cpu_hold"},   cpu_hold,   0);
    check({tag, "_err"},        err,        0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    xsum     = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b1;

    // Basic two-word load
    frame_q = '{16'h0123, 16'h0045};
    do_start();
    check("t1_in_ready", in_ready, 1);
    check("t1_cpu_hold", cpu_hold, 1);
    send_frame(0, 1'b0);
    check_done("t1", 2);

    // Same stream with random in_valid gaps
    do_start();
    send_frame(3, 1'b0);
    check_done("t2", 2);

    // start while busy is ignored
    frame_q = '{16'h01FF, 16'h0000, 16'h0155};
    do_start();
    send_frame(1, 1'b1);
    check_done("busy_start", 3);

    // Empty program
    frame_q.delete();
    do_start();
    send_frame(0, 1'b0);
    check("t3_load_done_next", load_done, 1);
    check_done("t3", 0);

    // Nonzero unused hi bit
    do_start();
    send_ok(8'h00, 0);
    send_ok(8'h01, 0);
    send_ok(8'h02, 0);
    check("t4_err",       err,       1);
    check("t4_in_ready",  in_ready,  0);
    check("t4_cpu_hold",  cpu_hold,  1);
    check("t4_load_done", load_done, 0);
    send_byte(8'h7F, 0, acc);
    check("t4_lo_refused", acc, 0);
    repeat (2) @(negedge clk);
    check("t4_word_count", word_count, 0);
    check("t4_sb_empty", sb.size(), 0);

    // Length one past the address space
    do_start();
    send_ok(8'h10, 0);
    send_ok(8'h01, 0);
    check("too_long_err", err, 1);
    check("too_long_in_ready", in_ready, 0);

    // Asynchronous reset mid-load, then a clean reload
    frame_q = '{16'h0123, 16'h0045};
    do_start();
    send_ok(8'h00, 0);
    send_ok(8'h02, 0);
    send_ok(8'h01, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("t5_rst");
    @(negedge clk);
    reset = 1'b1;
    do_start();
    send_frame(0, 1'b0);
    check_done("t5", 2);

`ifdef LOADER_CHECKSUM_EN
    // Checksum covers both length bytes and the payload: 00^01^00^AA = AB
    do_start();
    send_ok(8'h00, 0);
    send_ok(8'h01, 0);
    send_ok(8'h00, 0);
    sb.push_back('{a: D'(0), d: W'(9'h0AA)});
    send_ok(8'hAA, 0);
    send_ok(8'hAB, 0);
    check_done("t6_good", 1);
    do_start();
    send_ok(8'h00, 0);
    send_ok(8'h01, 0);
    send_ok(8'h00, 0);
    sb.push_back('{a: D'(0), d: W'(9'h0AA)});
    send_ok(8'hAA, 0);
    send_ok(8'hAA, 0);
    repeat (2) @(negedge clk);
    check("t6_bad_err", err, 1);
    check("t6_bad_cpu_hold", cpu_hold, 1);
    check("t6_bad_sb_empty", sb.size(), 0);
`endif

    // Full address space: 2**D words, count parks at the last address
    frame_q.delete();
    for (int k = 0; k < (1 << D); k++) frame_q.push_back(16'((k * 37) % 512));
    do_start();
    send_frame(0, 1'b0);
    check_done("full", (1 << D) - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
